// File: rtl/led_key_ctrl.sv
// Key front end for the LED flow stage: sync, shared-counter debounce, press flags and run/dir/speed mode FSM.
// Optional build macro LED_KEY_AUTOREPEAT_EN adds auto-repeat of key2 (speed step) while it is held.
//
// state   | meaning
// ST_STOP | flow_en = 0, LEDs hold the current pattern
// ST_RUN  | flow_en = 1, LEDs advance
module led_key_ctrl #(
  parameter logic [23:0] DEBOUNCE_CNT = 24'd1_000_000,
  parameter logic [23:0] REPEAT_CNT   = 24'd10_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key,
  output logic [3:0] key_value,
  output logic [3:0] key_flag,
  output logic       flow_en,
  output logic       flow_dir,
  output logic [1:0] speed_sel
);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  logic [3:0]  key_s1_q;
  logic [3:0]  key_sync_q;
  logic [3:0]  key_sync_dly_q;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  key_value_q, key_value_d;
  logic [3:0]  key_value_dly_q;
  logic [3:0]  key_flag_q, key_flag_d;
  logic        key_chg;
  logic        rep_hit;

  state_t      state_q;
  logic        flow_en_q;
  logic        flow_dir_q;
  logic [1:0]  speed_q;

  assign key_chg = (key_sync_q != key_sync_dly_q);

  // A change anywhere reloads the shared window, so bounces keep pushing acceptance out.
  always_comb begin
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    if (key_chg) begin
      cnt_d = DEBOUNCE_CNT;
    end else if (cnt_q != 24'd0) begin
      cnt_d = cnt_q - 24'd1;
      if (cnt_q == 24'd1) begin
        key_value_d = key_sync_q;
      end
    end
  end

  assign key_flag_d = (key_value_dly_q & ~key_value_q) | {1'b0, rep_hit, 2'b00};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1_q        <= 4'b1111;
      key_sync_q      <= 4'b1111;
      key_sync_dly_q  <= 4'b1111;
      cnt_q           <= 24'd0;
      key_value_q     <= 4'b1111;
      key_value_dly_q <= 4'b1111;
      key_flag_q      <= 4'b0000;
    end else begin
      key_s1_q        <= key;
      key_sync_q      <= key_s1_q;
      key_sync_dly_q  <= key_sync_q;
      cnt_q           <= cnt_d;
      key_value_q     <= key_value_d;
      key_value_dly_q <= key_value_q;
      key_flag_q      <= key_flag_d;
    end
  end

`ifdef LED_KEY_AUTOREPEAT_EN
  logic [23:0] rep_q, rep_d;

  // Counter sits at 0 in every key2 flag cycle, so repeats land REPEAT_CNT cycles apart.
  assign rep_hit = ~key_value_q[2] && (rep_q == REPEAT_CNT - 24'd1);
  assign rep_d   = (key_value_q[2] || key_flag_d[2]) ? 24'd0 : rep_q + 24'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rep_q <= 24'd0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat_cnt;

  assign unused_repeat_cnt = ^REPEAT_CNT;
  assign rep_hit           = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_STOP;
      flow_en_q  <= 1'b0;
      flow_dir_q <= 1'b0;
      speed_q    <= 2'd0;
    end else if (key_flag_q[3]) begin
      state_q    <= ST_STOP;
      flow_en_q  <= 1'b0;
      flow_dir_q <= 1'b0;
      speed_q    <= 2'd0;
    end else begin
      if (key_flag_q[0]) begin
        case (state_q)
          ST_STOP: begin
            state_q   <= ST_RUN;
            flow_en_q <= 1'b1;
          end
          default: begin
            state_q   <= ST_STOP;
            flow_en_q <= 1'b0;
          end
        endcase
      end
      if (key_flag_q[1]) begin
        flow_dir_q <= ~flow_dir_q;
      end
      if (key_flag_q[2]) begin
        speed_q <= speed_q + 2'd1;
      end
    end
  end

  assign key_value = key_value_q;
  assign key_flag  = key_flag_q;
  assign flow_en   = flow_en_q;
  assign flow_dir  = flow_dir_q;
  assign speed_sel = speed_q;

endmodule

// File: doc/led_key_ctrl.md
# led_key_ctrl

Upstream control stage for the LED flow pattern generator. It synchronises and debounces the four active-low board keys and emits one-cycle press flags. A small mode state machine turns those flags into run/stop, direction and speed controls, which the flow stage consumes directly. All outputs are registered in the sys_clk domain.

## Interface

Parameters:
- DEBOUNCE_CNT, 24'd1_000_000, stable-input time in sys_clk cycles before a key level is accepted (20 ms at 50 MHz); legal range 2..2^24-1.
- REPEAT_CNT, 24'd10_000_000, auto-repeat period in cycles (0.2 s); used only when LED_KEY_AUTOREPEAT_EN is defined.

Ports:
- sys_clk  input  1  system clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- sys_rst_n  input  1  asynchronous active-low reset.
- key  input  4  raw key inputs, active-low, asynchronous to sys_clk.
- key_value  output  4  debounced key level; 1 = released.
- key_flag  output  4  one-cycle pulse per debounced press (1→0 transition of key_value).
- flow_en  output  1  1 = LEDs advance, 0 = hold the current pattern.
- flow_dir  output  1  0 = LED1→LED4, 1 = LED4→LED1.
- speed_sel  output  2  step-period select for the flow stage; 0 is the slowest.

## Operation

- Synchroniser: two flops per bit (key_s1, key_sync), followed by a delay flop key_sync_d; all reset to 4'b1111.
- Debounce: a single shared 24-bit down-counter cnt, reset value 0.
  - If key_sync != key_sync_d, cnt <= DEBOUNCE_CNT. This reload has priority, so any change during a countdown restarts it.
  - Otherwise, if cnt != 0, cnt <= cnt - 1.
  - When cnt == 1 and there is no change, key_value <= key_sync on that edge.
- Flag: key_flag <= key_value_d & ~key_value, where key_value_d is key_value delayed by one cycle. Key releases produce no flag.
- Mode FSM, two states. STOP: flow_en = 0. RUN: flow_en = 1.
  - key_flag[0]: STOP↔RUN.
  - key_flag[1]: flow_dir toggles, in either state.
  - key_flag[2]: speed_sel + 1, wrapping 3→0.
  - key_flag[3]: return to defaults (STOP, flow_dir 0, speed_sel 0). This has priority over all other flags in the same cycle.
  - Simultaneous flags [2:0] with key_flag[3] = 0 are applied together in the same cycle.

## Timing

- Reset values: key_value 4'b1111, key_flag 0, flow_en 0, flow_dir 0, speed_sel 0, FSM in STOP, cnt 0.
- Press latency for a raw key change first sampled at edge 1 and held stable:
  - key_value changes at edge DEBOUNCE_CNT+3.
  - key_flag pulses high for exactly one cycle after edge DEBOUNCE_CNT+4.
  - FSM outputs update at edge DEBOUNCE_CNT+5.
- Bounce: any transition restarts the full DEBOUNCE_CNT window. A burst of bounces followed by a stable level gives exactly one key_value update.
- Multiple keys changing within one window are accepted together at the end of the window.
- Reset mid-operation: all state returns to reset values immediately. A key still held when reset is released is seen as a new press, and a fresh flag follows DEBOUNCE_CNT+4 edges later.
- The flow stage samples flow_en, flow_dir and speed_sel at any time. These outputs change at most once per accepted press.

## Configuration

- LED_KEY_AUTOREPEAT_EN defined: while key_value[2] stays 0, a repeat counter runs.
  - Counter value: DEBOUNCE_CNT+REPEAT_CNT-ish is not used; instead the counter starts at 0 on the key_flag[2] cycle.
  - Each time it reaches REPEAT_CNT-1, it asserts an extra key_flag[2] pulse and wraps to 0.
  - Release clears the counter immediately. Keys 0, 1 and 3 never repeat.
- LED_KEY_AUTOREPEAT_EN undefined: no repeat logic is built and REPEAT_CNT is ignored. Holding key2 gives one flag only.

## Test plan

Parameters for all scenarios: DEBOUNCE_CNT = 10, REPEAT_CNT = 8.

1. After reset, key[0] driven low at edge 1 and held 40 cycles → key_value[0] = 0 at edge 13, key_flag[0] high for one cycle after edge 14, flow_en = 1 at edge 15. Release and re-press → flow_en = 0.
2. key[1] toggled every 3 cycles for 24 cycles, then held low → exactly one key_flag[1], flow_dir = 1.
3. Five separate clean presses of key[2] → speed_sel steps 1, 2, 3, 0, 1. flow_en and flow_dir are unchanged.
4. From RUN with flow_dir 1 and speed_sel 2, key[3] and key[0] pressed in the same cycle → flow_en 0, flow_dir 0, speed_sel 0.
5. sys_rst_n pulsed low while cnt = 5 with key[0] still held → all outputs at reset values immediately. After reset release, key_flag[0] pulses 14 edges later and flow_en = 1.
6. LED_KEY_AUTOREPEAT_EN defined, key[2] held 40 cycles past its first flag → 5 extra key_flag[2] pulses, spaced 8 cycles apart. Without the macro, only one flag occurs.
